spi_config_receiver: RTL and testbench
======================================

# spi_config_receiver

Chip-side receiver for the serial configuration interface driven by the FPGA configuration generator (GRST, gated serial clock, SIN, REGSEL). The block runs on the system clock and oversamples the serial clock. Each frame is a slave-select phase with REGSEL high, then a data phase with REGSEL low. The block decodes each frame, commits the 30-bit data word into one of NUM_SLAVES configuration registers, and offers a registered readback port.

## Interface
- NUM_SLAVES, 23: number of configuration registers; legal addresses 0..NUM_SLAVES-1.
- ADDR_W, 5: slave-select width, shifted MSB-first.
- DATA_W, 30: data word width, shifted LSB-first.

- SCLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- SCK  in  1  gated serial clock from the generator; asynchronous to SCLK.
- SIN  in  1  serial data; launched on SCK falling edge, sampled on SCK rising edge.
- REGSEL  in  1  1 = slave-select bits, 0 = data bits.
- GRST  in  1  chip global reset, active-high; clears the register file.
- rd_addr  in  ADDR_W  readback address.
- rd_data  out  DATA_W  registered readback; 0 for an illegal rd_addr.
- wr_valid  out  1  one-cycle pulse on commit.
- wr_addr  out  ADDR_W  address of the last commit; held.
- wr_data  out  DATA_W  data of the last commit; held.
- addr_err  out  1  one-cycle pulse when a completed frame has address ≥ NUM_SLAVES.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- busy  out  1  high in ADDR or DATA.

## Operation
- Front end:
  - SCK, SIN, REGSEL and GRST pass through equal-depth input stages.
  - sck_rise is true for one SCLK cycle per SCK rising edge. The SIN and REGSEL values used on that cycle are the samples aligned with that edge.
- FSM: IDLE, ADDR, DATA, DONE. State changes only on sck_rise, except for resets.
  - IDLE, sample REGSEL=1: go to ADDR; the bit enters addr_sr; addr_cnt=1.
  - IDLE, sample REGSEL=0: bit ignored.
  - ADDR, REGSEL=1: addr_sr shifts left, new bit at LSB; addr_cnt saturates at ADDR_W. With more than ADDR_W bits, the last ADDR_W bits are kept.
  - ADDR, REGSEL=0 with addr_cnt=ADDR_W: go to DATA; the bit is stored at data bit 0; data_cnt=1.
  - ADDR, REGSEL=0 with addr_cnt<ADDR_W: frame_err; go to DONE.
  - DATA, REGSEL=0: bit stored at data bit data_cnt; data_cnt increments.
  - DATA, data_cnt reaches DATA_W: the frame completes.
    - Address legal: write the register, pulse wr_valid, update wr_addr and wr_data.
    - Address illegal: pulse addr_err; no write; wr_addr and wr_data unchanged.
    - Then go to DONE.
  - DATA, REGSEL=1 before DATA_W bits: frame_err; no write; go to ADDR; the bit becomes the first address bit (addr_cnt=1).
  - DONE, REGSEL=0: bits ignored. DONE, REGSEL=1: go to ADDR as from IDLE.
- GRST synchronized high:
  - All registers clear to 0; FSM goes to IDLE; counters clear.
  - Held while GRST stays high. wr_addr and wr_data are kept.
- RST: every register and output clears to 0; FSM goes to IDLE.
- Precedence: RST > GRST > sck_rise.
- Readback: rd_data <= reg[rd_addr], or 0 if rd_addr ≥ NUM_SLAVES. A commit and a read of the same address in the same cycle returns the old value; the new value appears the next cycle.

## Timing
- Reset values: rd_data, wr_addr and wr_data are 0; wr_valid, addr_err, frame_err and busy are 0.
- Latency with SPI_RX_SYNC_EN defined:
  - sck_rise occurs 3 SCLK cycles after SCK rises at the pin.
  - wr_valid occurs 1 cycle after the sck_rise of the last data bit.
  - The register file update is visible on rd_data 1 cycle after wr_valid, for a static rd_addr.
- Latency without the macro: sck_rise occurs 1 cycle after the SCK rise; all other latencies unchanged.
- SCK high and low time: each ≥ 4 SCLK periods with the macro, ≥ 2 without. SIN and REGSEL must be stable for the same window around SCK rise.
- busy rises on the cycle after the sck_rise that enters ADDR.
- busy falls on the cycle after the sck_rise that enters DONE, or on a reset.
- wr_valid, addr_err and frame_err are mutually exclusive. Each is high for exactly one cycle.

## Configuration
- SPI_RX_SYNC_EN defined:
  - Two-flop synchronizer on each of SCK, SIN, REGSEL and GRST, plus an SCK edge register.
  - Required whenever SCK is asynchronous to SCLK.
- SPI_RX_SYNC_EN undefined:
  - Single edge-detect register only; inputs must be synchronous to SCLK.
  - Latency and minimum pulse widths reduce as stated in Timing; behaviour is otherwise identical.

## Test plan
- RST, then frame addr=10 (01010 MSB-first) with data=35 LSB-first: wr_valid once, wr_addr=10, wr_data=35; rd_addr=10 gives rd_data=35 and other addresses give 0.
- Back-to-back frames 22/2 then 16/100: two wr_valid pulses; reg[22]=2 and reg[16]=100; reg[10] unchanged.
- Frame addr=25 with data=7 (NUM_SLAVES=23): addr_err pulse, no wr_valid, rd_addr=25 gives 0, wr_addr unchanged.
- REGSEL rises after 12 data bits, then a full frame 3/0x3FFFFFFF follows: frame_err once, then reg[3]=0x3FFFFFFF; address 3 gets no partial write.
- 40 extra REGSEL=0 bits after a commit: no further pulses; busy stays 0 in DONE.
- GRST high for 10 cycles, both mid-frame and after writes: all registers read 0, FSM back to IDLE, busy=0. The next frame commits normally.

Source files
------------

// File: rtl/spi_config_receiver.sv
// Serial configuration receiver: oversamples a gated SCK on SCLK, decodes
// REGSEL-framed address/data words into a register file with readback.
// Optional macro SPI_RX_SYNC_EN adds two-flop synchronizers on all serial inputs.
module spi_config_receiver #(
  parameter int NUM_SLAVES = 23,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 30
) (
  input  logic              SCLK,
  input  logic              RST,
  input  logic              SCK,
  input  logic              SIN,
  input  logic              REGSEL,
  input  logic              GRST,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              addr_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int ACW = $clog2(ADDR_W + 1);
  localparam int DCW = $clog2(DATA_W + 1);
  localparam logic [ACW-1:0]  ADDR_CNT_MAX = ACW'(ADDR_W);
  localparam logic [DCW-1:0]  DATA_LAST    = DCW'(DATA_W - 1);
  localparam logic [ADDR_W:0] NSLAVES      = (ADDR_W + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  logic sck_s, sin_s, regsel_s, grst_s;
  logic sck_prev_q;
  logic sck_rise;

`ifdef SPI_RX_SYNC_EN
  // Input stage p0/p1: two-flop synchronizer, bit order {GRST, REGSEL, SIN, SCK}
  logic [3:0] in_p0, in_p1;

  always_ff @(posedge SCLK) begin
    if (RST) begin
      in_p0 <= '0;
      in_p1 <= '0;
    end else begin
      in_p0 <= {GRST, REGSEL, SIN, SCK};
      in_p1 <= in_p0;
    end
  end

  assign sck_s    = in_p1[0];
  assign sin_s    = in_p1[1];
  assign regsel_s = in_p1[2];
  assign grst_s   = in_p1[3];
`else
  assign sck_s    = SCK;
  assign sin_s    = SIN;
  assign regsel_s = REGSEL;
  assign grst_s   = GRST;
`endif

  // Edge-detect stage: SIN/REGSEL seen here have the same depth as sck_s
  always_ff @(posedge SCLK) begin
    if (RST) sck_prev_q <= 1'b0;
    else     sck_prev_q <= sck_s;
  end

  assign sck_rise = sck_s & ~sck_prev_q;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_sr_q, addr_sr_d;
  logic [ACW-1:0]      addr_cnt_q, addr_cnt_d;
  logic [DATA_W-1:0]   data_sr_q, data_sr_d;
  logic [DCW-1:0]      data_cnt_q, data_cnt_d;
  logic                commit, aerr, ferr;
  logic                addr_legal;
  logic                wr_valid_q, addr_err_q, frame_err_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [DATA_W-1:0]   regs_q [NUM_SLAVES];
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_legal;

  assign addr_legal = {1'b0, addr_sr_q} < NSLAVES;
  assign rd_legal   = {1'b0, rd_addr} < NSLAVES;

  always_comb begin
    state_d    = state_q;
    addr_sr_d  = addr_sr_q;
    addr_cnt_d = addr_cnt_q;
    data_sr_d  = data_sr_q;
    data_cnt_d = data_cnt_q;
    commit     = 1'b0;
    aerr       = 1'b0;
    ferr       = 1'b0;
    if (sck_rise) begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (regsel_s) begin
            state_d    = ST_ADDR;
            addr_sr_d  = {{(ADDR_W-1){1'b0}}, sin_s};
            addr_cnt_d = ACW'(1);
          end
        end
        ST_ADDR: begin
          if (regsel_s) begin
            // Oversized select fields keep only the most recent ADDR_W bits
            addr_sr_d = {addr_sr_q[ADDR_W-2:0], sin_s};
            if (addr_cnt_q != ADDR_CNT_MAX) addr_cnt_d = addr_cnt_q + 1'b1;
          end else if (addr_cnt_q == ADDR_CNT_MAX) begin
            state_d      = ST_DATA;
            data_sr_d    = '0;
            data_sr_d[0] = sin_s;
            data_cnt_d   = DCW'(1);
          end else begin
            ferr    = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DATA: begin
          if (regsel_s) begin
            // Early REGSEL restarts a frame; this bit is its first address bit
            ferr       = 1'b1;
            state_d    = ST_ADDR;
            addr_sr_d  = {{(ADDR_W-1){1'b0}}, sin_s};
            addr_cnt_d = ACW'(1);
            data_cnt_d = '0;
          end else begin
            data_sr_d[data_cnt_q] = sin_s;
            if (data_cnt_q == DATA_LAST) begin
              commit     = addr_legal;
              aerr       = ~addr_legal;
              state_d    = ST_DONE;
              data_cnt_d = '0;
            end else begin
              data_cnt_d = data_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      addr_sr_q   <= '0;
      addr_cnt_q  <= '0;
      data_sr_q   <= '0;
      data_cnt_q  <= '0;
      wr_valid_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else if (grst_s) begin
      // Global reset wipes frame state but keeps the last-commit record
      state_q     <= ST_IDLE;
      addr_sr_q   <= '0;
      addr_cnt_q  <= '0;
      data_sr_q   <= '0;
      data_cnt_q  <= '0;
      wr_valid_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_sr_q   <= addr_sr_d;
      addr_cnt_q  <= addr_cnt_d;
      data_sr_q   <= data_sr_d;
      data_cnt_q  <= data_cnt_d;
      wr_valid_q  <= commit;
      addr_err_q  <= aerr;
      frame_err_q <= ferr;
      if (commit) begin
        wr_addr_q <= addr_sr_q;
        wr_data_q <= data_sr_d;
      end
    end
  end

  // Register file and readback: a same-cycle read sees the pre-commit value
  always_ff @(posedge SCLK) begin
    if (RST || grst_s) begin
      for (int i = 0; i < NUM_SLAVES; i++) regs_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (commit) regs_q[addr_sr_q] <= data_sr_d;
      rd_data_q <= rd_legal ? regs_q[rd_addr] : '0;
    end
  end

  assign rd_data   = rd_data_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign addr_err  = addr_err_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == ST_ADDR) || (state_q == ST_DATA);

endmodule

// File: tb/tb_spi_config_receiver.sv
// Scoreboard bench for spi_config_receiver: directed frames push expected
// events; a monitor pops and compares on every wr_valid/addr_err/frame_err.
`timescale 1ns/1ps
module tb_spi_config_receiver;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 30;
  localparam int EV_WR = 0, EV_AERR = 1, EV_FERR = 2;

  logic              SCLK = 1'b0;
  logic              RST, SCK, SIN, REGSEL, GRST;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid, addr_err, frame_err, busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  typedef struct {
    int                kind;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  spi_config_receiver dut (
    .SCLK(SCLK), .RST(RST), .SCK(SCK), .SIN(SIN), .REGSEL(REGSEL), .GRST(GRST),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .addr_err(addr_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 SCLK = ~SCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic rs, input logic b);
    @(negedge SCLK);
    SCK = 1'b0; REGSEL = rs; SIN = b;
    repeat (6) @(negedge SCLK);
    SCK = 1'b1;
    repeat (6) @(negedge SCLK);
    SCK = 1'b0;
  endtask

  task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int nd);
    for (int i = ADDR_W - 1; i >= 0; i--) send_bit(1'b1, a[i]);
    for (int i = 0; i < nd; i++) send_bit(1'b0, d[i]);
  endtask

  task automatic chk_rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] req);
    @(negedge SCLK);
    rd_addr = a;
    repeat (2) @(negedge SCLK);
    chk($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(req));
  endtask

  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge SCLK) begin
    if (RST === 1'b0 && (wr_valid || addr_err || frame_err)) begin
      checks++;
      if ({wr_valid, addr_err, frame_err} != 3'b100 &&
          {wr_valid, addr_err, frame_err} != 3'b010 &&
          {wr_valid, addr_err, frame_err} != 3'b001) begin
        failures++;
        $display("FAIL pulse_exclusive actual=%b required=onehot", {wr_valid, addr_err, frame_err});
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse actual=%b required=none", {wr_valid, addr_err, frame_err});
      end else begin
        ev_t e;
        int  k;
        e = exp_q.pop_front();
        k = wr_valid ? EV_WR : (addr_err ? EV_AERR : EV_FERR);
        if (k != e.kind) begin
          failures++;
          $display("FAIL event_kind actual=%0d required=%0d", k, e.kind);
        end else if (k == EV_WR && (wr_addr !== e.a || wr_data !== e.d)) begin
          failures++;
          $display("FAIL commit actual=%0d/0x%0h required=%0d/0x%0h", wr_addr, wr_data, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; GRST = 1'b0; SCK = 1'b0; SIN = 1'b0; REGSEL = 1'b0; rd_addr = '0;
    repeat (4) @(negedge SCLK);
    chk("reset_rd_data", 32'(rd_data), 0);
    chk("reset_wr_addr", 32'(wr_addr), 0);
    chk("reset_wr_data", 32'(wr_data), 0);
    chk("reset_pulses", {29'd0, wr_valid, addr_err, frame_err}, 0);
    chk("reset_busy", 32'(busy), 0);
    RST = 1'b0;
    repeat (4) @(negedge SCLK);

    // addr 10 = 01010, data 35
    push(EV_WR, 5'd10, 30'd35);
    send_frame(5'd10, 30'd35, DATA_W);
    repeat (8) @(negedge SCLK);
    chk("busy_after_commit", 32'(busy), 0);
    chk("wr_addr_held", 32'(wr_addr), 10);
    chk_rd(5'd10, 30'd35);
    chk_rd(5'd0, 30'd0);
    chk_rd(5'd22, 30'd0);

    // Back-to-back frames
    push(EV_WR, 5'd22, 30'd2);
    push(EV_WR, 5'd16, 30'd100);
    send_frame(5'd22, 30'd2, DATA_W);
    send_frame(5'd16, 30'd100, DATA_W);
    repeat (8) @(negedge SCLK);
    chk_rd(5'd22, 30'd2);
    chk_rd(5'd16, 30'd100);
    chk_rd(5'd10, 30'd35);

    // Illegal address 25
    push(EV_AERR, 5'd25, 30'd7);
    send_frame(5'd25, 30'd7, DATA_W);
    repeat (8) @(negedge SCLK);
    chk_rd(5'd25, 30'd0);
    chk("wr_addr_after_aerr", 32'(wr_addr), 16);
    chk("wr_data_after_aerr", 32'(wr_data), 100);

    // Aborted frame after 12 data bits, then a full frame to the same address
    send_frame(5'd3, 30'h3FFF_FFFF, 12);
    repeat (4) @(negedge SCLK);
    chk("busy_mid_frame", 32'(busy), 1);
    chk_rd(5'd3, 30'd0);
    push(EV_FERR, 5'd0, 30'd0);
    push(EV_WR, 5'd3, 30'h3FFF_FFFF);
    send_frame(5'd3, 30'h3FFF_FFFF, DATA_W);
    repeat (8) @(negedge SCLK);
    chk_rd(5'd3, 30'h3FFF_FFFF);

    // Trailing data bits in DONE are ignored
    for (int i = 0; i < 40; i++) send_bit(1'b0, i[0]);
    repeat (8) @(negedge SCLK);
    chk("busy_in_done", 32'(busy), 0);
    chk("wr_data_after_extra", 32'(wr_data), 32'h3FFF_FFFF);

    // GRST mid-frame
    send_frame(5'd7, 30'h15, 5);
    repeat (4) @(negedge SCLK);
    chk("busy_before_grst", 32'(busy), 1);
    @(negedge SCLK);
    GRST = 1'b1;
    repeat (10) @(negedge SCLK);
    chk("busy_during_grst", 32'(busy), 0);
    GRST = 1'b0;
    repeat (4) @(negedge SCLK);
    chk("busy_after_grst", 32'(busy), 0);
    chk_rd(5'd10, 30'd0);
    chk_rd(5'd22, 30'd0);
    chk_rd(5'd3, 30'd0);
    chk("wr_addr_kept", 32'(wr_addr), 3);
    chk("wr_data_kept", 32'(wr_data), 32'h3FFF_FFFF);
    push(EV_WR, 5'd7, 30'h12345);
    send_frame(5'd7, 30'h12345, DATA_W);
    repeat (8) @(negedge SCLK);
    chk_rd(5'd7, 30'h12345);

    // GRST after writes
    @(negedge SCLK);
    GRST = 1'b1;
    repeat (10) @(negedge SCLK);
    GRST = 1'b0;
    repeat (4) @(negedge SCLK);
    chk_rd(5'd7, 30'd0);
    push(EV_WR, 5'd22, 30'h2AAA_AAAA);
    send_frame(5'd22, 30'h2AAA_AAAA, DATA_W);
    repeat (8) @(negedge SCLK);
    chk_rd(5'd22, 30'h2AAA_AAAA);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge SCLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
